// File: rtl/wta_pkg.sv
// Shared types and arithmetic helpers for the winner-take-all LIF array.
package wta_pkg;

    localparam int unsigned WIDE_W = 32;

    typedef logic [WIDE_W-1:0] wide_t;

    typedef enum logic {
        WTA_INTEGRATE = 1'b0,
        WTA_REFRACT   = 1'b1
    } wta_state_e;

    // Unsigned add clamped to the largest w-bit value; w must be below WIDE_W.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        wide_t max_v;
        wide_t sum;
        max_v = (wide_t'(1) << w) - wide_t'(1);
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

    // Exponential decay step: removes a 1/2^shift fraction of the value.
    function automatic wide_t leak(input wide_t a, input int unsigned shift);
        return a - (a >> shift);
    endfunction

endpackage

// File: rtl/wta_argmax.sv
// Combinational max-with-index over the masked accumulators; lowest index wins ties.
module wta_argmax #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic [ACC_W-1:0]        acc_i [N_CH],
    input  logic [N_CH-1:0]         mask_i,
    output logic                    any_c,
    output logic [$clog2(N_CH)-1:0] idx_c
);

    localparam int unsigned ID_W = $clog2(N_CH);

    logic              found;
    logic [ID_W-1:0]   best_idx;
    logic [ACC_W-1:0]  best_val;

    // Strict greater-than keeps the earliest index on equal values.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_val = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (mask_i[i] && (!found || (acc_i[i] > best_val))) begin
                found    = 1'b1;
                best_idx = ID_W'(i);
                best_val = acc_i[i];
            end
        end
    end

    assign any_c = found;
    assign idx_c = best_idx;

endmodule

// File: rtl/wta_lif_array.sv
// Winner-take-all integrate-and-fire array with lateral inhibition and refractory hold-off.
// Optional leaky integration is enabled by defining WTA_LEAK_EN.
module wta_lif_array
    import wta_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned IN_W        = 4,
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned REFRACT_CYC = 4,
    parameter int unsigned LEAK_SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     in_valid,
    input  logic [N_CH*IN_W-1:0]     in_data,
    input  logic [ACC_W-1:0]         threshold,
    output logic                     winner_valid,
    output logic [$clog2(N_CH)-1:0]  winner_id,
    output logic                     busy
);

    localparam int unsigned ID_W  = $clog2(N_CH);
    localparam int unsigned CNT_W = $clog2(REFRACT_CYC + 1);

`ifdef WTA_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    wta_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q [N_CH];
    logic [ACC_W-1:0]  acc_d [N_CH];
    logic              winner_valid_q, winner_valid_d;
    logic [ID_W-1:0]   winner_id_q, winner_id_d;
    logic              busy_q, busy_d;

    logic [N_CH-1:0]   hit;
    logic              any_hit;
    logic [ID_W-1:0]   win_idx;

    // Threshold is compared live against the registered accumulators.
    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            hit[i] = (threshold != '0) && (acc_q[i] >= threshold);
        end
    end

    wta_argmax #(
        .N_CH  (N_CH),
        .ACC_W (ACC_W)
    ) u_argmax (
        .acc_i  (acc_q),
        .mask_i (hit),
        .any_c  (any_hit),
        .idx_c  (win_idx)
    );

    always_comb begin
        logic [IN_W-1:0] in_ch;
        wide_t           base;

        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        winner_valid_d = 1'b0;
        winner_id_d    = winner_id_q;
        busy_d         = busy_q;
        in_ch          = '0;
        base           = '0;

        if (ena) begin
            unique case (state_q)
                WTA_INTEGRATE: begin
                    if (any_hit) begin
                        // Firing clears every channel; same-cycle input is dropped.
                        winner_valid_d = 1'b1;
                        winner_id_d    = win_idx;
                        cnt_d          = CNT_W'(REFRACT_CYC);
                        busy_d         = 1'b1;
                        state_d        = WTA_REFRACT;
                        for (int i = 0; i < int'(N_CH); i++) begin
                            acc_d[i] = '0;
                        end
                    end else begin
                        for (int i = 0; i < int'(N_CH); i++) begin
                            in_ch = in_valid ? in_data[i*IN_W +: IN_W] : '0;
                            base  = LEAK_EN ? leak(wide_t'(acc_q[i]), LEAK_SHIFT)
                                            : wide_t'(acc_q[i]);
                            if (LEAK_EN || in_valid) begin
                                acc_d[i] = ACC_W'(sat_add(base, wide_t'(in_ch), ACC_W));
                            end
                        end
                    end
                end
                WTA_REFRACT: begin
                    for (int i = 0; i < int'(N_CH); i++) begin
                        acc_d[i] = '0;
                    end
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = WTA_INTEGRATE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = WTA_INTEGRATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WTA_INTEGRATE;
            cnt_q          <= '0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            busy_q         <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
            busy_q         <= busy_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_wta_lif_array.sv
// Directed and randomized bench for wta_lif_array against a cycle-level behavioural model.
module tb_wta_lif_array;

    localparam int N_CH  = 4;
    localparam int IN_W  = 4;
    localparam int ACC_W = 8;
    localparam int RC    = 4;
    localparam int LS    = 2;
    localparam int ACC_MAX = 255;

`ifdef WTA_LEAK_EN
    localparam bit M_LEAK = 1'b1;
`else
    localparam bit M_LEAK = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 ena;
    logic                 in_valid;
    logic [N_CH*IN_W-1:0] in_data;
    logic [ACC_W-1:0]     threshold;
    logic                 winner_valid;
    logic [1:0]           winner_id;
    logic                 busy;

    wta_lif_array #(
        .N_CH        (N_CH),
        .IN_W        (IN_W),
        .ACC_W       (ACC_W),
        .REFRACT_CYC (RC),
        .LEAK_SHIFT  (LS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .threshold    (threshold),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ch [N_CH];
    int m_acc [N_CH];
    int m_rem;
    int m_wid;
    bit m_wv;

    int p1, p2, cnt, first, exp_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) m_acc[i] = 0;
        m_rem = 0;
        m_wid = 0;
        m_wv  = 1'b0;
    endtask

    // One clock of the reference behaviour, using the inputs present before the edge.
    task automatic model_edge();
        int best;
        int a;
        m_wv = 1'b0;
        if (ena !== 1'b1) return;
        if (m_rem > 0) begin
            m_rem--;
            return;
        end
        best = -1;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(threshold) != 0 && m_acc[i] >= int'(threshold) &&
                (best < 0 || m_acc[i] > m_acc[best])) best = i;
        end
        if (best >= 0) begin
            m_wv  = 1'b1;
            m_wid = best;
            m_rem = RC;
            for (int i = 0; i < N_CH; i++) m_acc[i] = 0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                a = m_acc[i];
                if (M_LEAK) a = a - a / (1 << LS);
                if (in_valid) a = a + ch[i];
                if (a > ACC_MAX) a = ACC_MAX;
                m_acc[i] = a;
            end
        end
    endtask

    task automatic step();
        in_data = {4'(ch[3]), 4'(ch[2]), 4'(ch[1]), 4'(ch[0])};
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("winner_valid", 32'(winner_valid), 32'(m_wv));
        chk("winner_id", 32'(winner_id), 32'(m_wid));
        chk("busy", 32'(busy), 32'(m_rem > 0));
    endtask

    task automatic drive(input bit v, input int a0, input int a1, input int a2, input int a3);
        in_valid = v;
        ch[0] = a0; ch[1] = a1; ch[2] = a2; ch[3] = a3;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        threshold = 8'd20;
        for (int i = 0; i < N_CH; i++) ch[i] = 0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wv", 32'(winner_valid), 32'd0);
        chk("rst_wid", 32'(winner_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        idle(10);

        // Single channel: 4 x 5 reaches 20
        for (int k = 0; k < 4; k++) drive(1'b1, 0, 0, 5, 0);
        drive(1'b0, 0, 0, 0, 0);
        chk("single_wv", 32'(winner_valid), 32'd1);
        chk("single_wid", 32'(winner_id), 32'd2);
        cnt = 32'(busy);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 0, 0, 0, 0);
            cnt += int'(busy);
        end
        chk("single_busy_len", 32'(cnt), 32'(RC));
        chk("single_busy_end", 32'(busy), 32'd0);

        // Tie between channels 1 and 3
        for (int k = 0; k < 2; k++) drive(1'b1, 0, 10, 0, 10);
        drive(1'b0, 0, 0, 0, 0);
        chk("tie_wv", 32'(winner_valid), 32'd1);
        chk("tie_wid", 32'(winner_id), 32'd1);
        idle(RC);

        // Larger accumulator wins
        threshold = 8'd10;
        drive(1'b1, 12, 15, 0, 0);
        drive(1'b0, 0, 0, 0, 0);
        chk("max_wv", 32'(winner_valid), 32'd1);
        chk("max_wid", 32'(winner_id), 32'd1);
        idle(RC);
        threshold = 8'd20;

        // Input during refractory is ignored; two samples needed afterwards
        p1 = 0; p2 = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 15, 0, 0, 0);
            if (winner_valid === 1'b1) begin
                if (p1 == 0) p1 = k; else if (p2 == 0) p2 = k;
            end
        end
        chk("refract_first", 32'(p1), 32'd3);
        chk("refract_gap", 32'(p2 - p1), 32'(RC + 3));
        idle(RC + 1);

        // ena low mid-refractory stretches busy
        for (int k = 0; k < 2; k++) drive(1'b1, 15, 0, 0, 0);
        drive(1'b0, 0, 0, 0, 0);
        chk("ena_wv", 32'(winner_valid), 32'd1);
        cnt = 32'(busy);
        drive(1'b0, 0, 0, 0, 0);
        cnt += int'(busy);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 15, 0, 0, 0);
            cnt += int'(busy);
        end
        ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 0, 0, 0, 0);
            cnt += int'(busy);
        end
        chk("ena_busy_len", 32'(cnt), 32'(RC + 3));

        // Saturation at 255 with threshold 255
`ifdef WTA_LEAK_EN
        exp_first = 0;
`else
        exp_first = 18;
`endif
        threshold = 8'd255;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 15, 0, 0, 0);
            if (winner_valid === 1'b1 && first == 0) first = k;
        end
        chk("sat_fire_step", 32'(first), 32'(exp_first));
        idle(RC + 2);

        // Threshold zero never fires, even when saturated
        threshold = 8'd0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 15, 0, 0, 0);
            cnt += int'(winner_valid);
        end
        chk("thr0_pulses", 32'(cnt), 32'd0);
        threshold = 8'd20;
        drive(1'b0, 0, 0, 0, 0);
        chk("thr_live_wv", 32'(winner_valid), 32'd1);
        idle(RC + 1);

        // Leak profile: 4 per cycle
`ifdef WTA_LEAK_EN
        exp_first = 0;
`else
        exp_first = 6;
`endif
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            drive(1'b1, 4, 0, 0, 0);
            if (winner_valid === 1'b1 && first == 0) first = k;
        end
        chk("leak_fire_step", 32'(first), 32'(exp_first));
        idle(RC + 8);

        // Async reset mid-pulse
        for (int k = 0; k < 2; k++) drive(1'b1, 0, 0, 0, 15);
        drive(1'b0, 0, 0, 0, 0);
        chk("arst_pre_wv", 32'(winner_valid), 32'd1);
        chk("arst_pre_wid", 32'(winner_id), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wv", 32'(winner_valid), 32'd0);
        chk("arst_wid", 32'(winner_id), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            ena      = ($urandom_range(0, 9) != 0);
            in_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < N_CH; i++) ch[i] = int'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                threshold = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(8, 120));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
